// File: rtl/idelay_ctrl_pkg.sv
// Shared definitions for the IDELAYE2 tap controller.
// Holds the FSM state encoding, the default tap width and settle time,
// and the width of the settle counter.
package idelay_ctrl_pkg;

  localparam int unsigned TAP_W_DEFAULT         = 5;
  localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;
  localparam int unsigned SETTLE_CNT_W          = 8;  // covers settle times 1..255
  localparam int unsigned STATE_W               = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_WAIT_RDY = 3'd0;
  localparam state_t ST_IDLE     = 3'd1;
  localparam state_t ST_LOAD     = 3'd2;
  localparam state_t ST_STEP     = 3'd3;
  localparam state_t ST_SETTLE   = 3'd4;
  localparam state_t ST_CHECK    = 3'd5;
  localparam state_t ST_DONE     = 3'd6;

endpackage

// File: rtl/idelay_settle_timer.sv
// Settle down-counter: a start pulse loads SETTLE_CYCLES, and done is high
// during the last of the SETTLE_CYCLES cycles that follow the start edge.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   start - load the counter (one cycle, on entry to the settle window)
//   done  - registered, high in the final cycle of the settle window
module idelay_settle_timer
  import idelay_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  logic                    done_q, done_d;

  // Count down to zero; flag the cycle in which the count reads one.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = SETTLE_CNT_W'(SETTLE_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - SETTLE_CNT_W'(1);
    end
    done_d = (cnt_d == SETTLE_CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;

endmodule

// File: rtl/idelay_tap_ctrl.sv
// IDELAYE2 tap controller. Waits for IDELAYCTRL ready, then accepts one
// request at a time: an absolute load (LD pulse) or a one-tap-at-a-time walk
// (CE pulses), each followed by a settle window, a readback check and a
// one-cycle done pulse. Losing rdy_in mid-operation aborts with an error.
// Ports:
//   clk, reset            - clock (also IDELAYE2 C), synchronous active-high reset
//   rdy_in                - IDELAYCTRL RDY
//   req_valid/req_ready   - request handshake; req_tap target, req_walk mode
//   done_valid            - one-cycle completion pulse
//   done_tap, done_err    - readback tap and error flag of the last operation
//   dly_ld, dly_ce, dly_inc, dly_cntvaluein - IDELAYE2 control
//   dly_cntvalueout       - IDELAYE2 readback
//   busy                  - high whenever the controller is not idle
module idelay_tap_ctrl
  import idelay_ctrl_pkg::*;
#(
  parameter int unsigned TAP_W         = TAP_W_DEFAULT,
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rdy_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAP_W-1:0] req_tap,
  input  logic             req_walk,
  output logic             done_valid,
  output logic [TAP_W-1:0] done_tap,
  output logic             done_err,
  output logic             dly_ld,
  output logic             dly_ce,
  output logic             dly_inc,
  output logic [TAP_W-1:0] dly_cntvaluein,
  input  logic [TAP_W-1:0] dly_cntvalueout,
  output logic             busy
);

  localparam int unsigned       STEP_W     = TAP_W + 1;
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(1) << TAP_W;

  state_t            state_q, state_d;
  logic [TAP_W-1:0]  target_q, target_d;
  logic              walk_q, walk_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              abort_q, abort_d;
  logic [TAP_W-1:0]  done_tap_q, done_tap_d;
  logic              done_err_q, done_err_d;
  logic [TAP_W-1:0]  cntvaluein_q, cntvaluein_d;
  logic              inc_q, inc_d;
  logic              req_ready_q, req_ready_d;
  logic              done_valid_q, done_valid_d;
  logic              ld_q, ld_d;
  logic              ce_q, ce_d;
  logic              busy_q, busy_d;

  logic              settle_start_c;
  logic              settle_done;
  logic              active_c;

  idelay_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .reset(reset),
    .start(settle_start_c),
    .done (settle_done)
  );

  // States in which losing rdy_in aborts the operation.
  assign active_c = (state_q == ST_LOAD) || (state_q == ST_STEP) ||
                    (state_q == ST_SETTLE) || (state_q == ST_CHECK);

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    walk_d       = walk_q;
    step_d       = step_q;
    abort_d      = abort_q;
    done_tap_d   = done_tap_q;
    done_err_d   = done_err_q;
    cntvaluein_d = cntvaluein_q;
    inc_d        = 1'b0;

    case (state_q)
      ST_WAIT_RDY: begin
        if (rdy_in) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!rdy_in) begin
          state_d = ST_WAIT_RDY;
        end else if (req_valid) begin
          target_d = req_tap;
          walk_d   = req_walk;
          step_d   = '0;
          abort_d  = 1'b0;
          if (!req_walk) begin
            state_d      = ST_LOAD;
            cntvaluein_d = req_tap;
          end else if (req_tap == dly_cntvalueout) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_STEP;
            inc_d   = (req_tap > dly_cntvalueout);
          end
        end
      end
      ST_LOAD: begin
        state_d = ST_SETTLE;
      end
      ST_STEP: begin
        step_d  = step_q + STEP_W'(1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_done) begin
          // Keep walking until the readback matches, bounded by the step limit.
          if (walk_q && (dly_cntvalueout != target_q) && (step_q != STEP_LIMIT)) begin
            state_d = ST_STEP;
            inc_d   = (target_q > dly_cntvalueout);
          end else begin
            state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        done_tap_d = dly_cntvalueout;
        done_err_d = (dly_cntvalueout != target_q);
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = (abort_q || !rdy_in) ? ST_WAIT_RDY : ST_IDLE;
      end
      default: begin
        state_d = ST_WAIT_RDY;
      end
    endcase

    // Loss of IDELAYCTRL ready overrides any in-flight transition.
    if (active_c && !rdy_in) begin
      state_d    = ST_DONE;
      abort_d    = 1'b1;
      done_tap_d = dly_cntvalueout;
      done_err_d = 1'b1;
      inc_d      = 1'b0;
    end

    req_ready_d  = (state_d == ST_IDLE);
    done_valid_d = (state_d == ST_DONE);
    ld_d         = (state_d == ST_LOAD);
    ce_d         = (state_d == ST_STEP);
    busy_d       = (state_d != ST_IDLE);
  end

  // Timer restarts on every entry into the settle window.
  assign settle_start_c = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_WAIT_RDY;
      target_q     <= '0;
      walk_q       <= 1'b0;
      step_q       <= '0;
      abort_q      <= 1'b0;
      done_tap_q   <= '0;
      done_err_q   <= 1'b0;
      cntvaluein_q <= '0;
      inc_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      done_valid_q <= 1'b0;
      ld_q         <= 1'b0;
      ce_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      walk_q       <= walk_d;
      step_q       <= step_d;
      abort_q      <= abort_d;
      done_tap_q   <= done_tap_d;
      done_err_q   <= done_err_d;
      cntvaluein_q <= cntvaluein_d;
      inc_q        <= inc_d;
      req_ready_q  <= req_ready_d;
      done_valid_q <= done_valid_d;
      ld_q         <= ld_d;
      ce_q         <= ce_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign done_valid     = done_valid_q;
  assign done_tap       = done_tap_q;
  assign done_err       = done_err_q;
  assign dly_ld         = ld_q;
  assign dly_ce         = ce_q;
  assign dly_inc        = inc_q;
  assign dly_cntvaluein = cntvaluein_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_idelay_tap_ctrl.sv
// Bench for idelay_tap_ctrl: an IDELAYE2 tap model, a per-cycle expected
// timeline built from request arithmetic, and directed scenarios.
module tb_idelay_tap_ctrl;

  localparam int unsigned TAP_W  = 5;
  localparam int unsigned SETTLE = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             rdy_in;
  logic             req_valid;
  logic             req_ready;
  logic [TAP_W-1:0] req_tap;
  logic             req_walk;
  logic             done_valid;
  logic [TAP_W-1:0] done_tap;
  logic             done_err;
  logic             dly_ld;
  logic             dly_ce;
  logic             dly_inc;
  logic [TAP_W-1:0] dly_cntvaluein;
  logic [TAP_W-1:0] dly_cntvalueout;
  logic             busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit ld;
    bit ce;
    bit inc;
    bit dv;
    int tap;
    bit err;
  } exp_t;

  exp_t exp_q[$];
  bit   tl_en = 1'b0;

  // IDELAYE2 tap register: LD loads, CE steps, readback is registered.
  logic [TAP_W-1:0] tap_m = '0;
  always @(posedge clk) begin
    if (dly_ld)      tap_m <= dly_cntvaluein;
    else if (dly_ce) tap_m <= dly_inc ? tap_m + TAP_W'(1) : tap_m - TAP_W'(1);
  end
  assign dly_cntvalueout = tap_m;

  always #5 clk = ~clk;

  idelay_tap_ctrl #(
    .TAP_W        (TAP_W),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rdy_in         (rdy_in),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_tap        (req_tap),
    .req_walk       (req_walk),
    .done_valid     (done_valid),
    .done_tap       (done_tap),
    .done_err       (done_err),
    .dly_ld         (dly_ld),
    .dly_ce         (dly_ce),
    .dly_inc        (dly_inc),
    .dly_cntvaluein (dly_cntvaluein),
    .dly_cntvalueout(dly_cntvalueout),
    .busy           (busy)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic exp_t mk(input bit ld, input bit ce, input bit inc, input bit dv,
                              input int tap, input bit err);
    exp_t e;
    e.ld = ld; e.ce = ce; e.inc = inc; e.dv = dv; e.tap = tap; e.err = err;
    return e;
  endfunction

  // Expected cycle-by-cycle activity after acceptance of a request.
  function automatic void build_timeline(input int tgt, input bit walk, input int cur);
    int n;
    if (!walk) begin
      exp_q.push_back(mk(1, 0, 0, 0, tgt, 0));
      for (int s = 0; s < int'(SETTLE); s++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    end else begin
      n = (tgt > cur) ? tgt - cur : cur - tgt;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back(mk(0, 1, tgt > cur, 0, 0, 0));
        for (int s = 0; s < int'(SETTLE); s++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      end
    end
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, 0, 1, tgt, 0));
  endfunction

  task automatic compare_loop();
    int   since = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) since = 0;
      else if (since < 2) since++;
      if (since >= 2) begin
        chk("ld_ce_exclusive", {31'd0, dly_ld & dly_ce}, 0);
        chk("busy_vs_ready", {31'd0, busy}, {31'd0, ~req_ready});
        if (tl_en) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("tl_busy", {31'd0, busy}, 1);
            chk("tl_ld", {31'd0, dly_ld}, {31'd0, e.ld});
            chk("tl_ce", {31'd0, dly_ce}, {31'd0, e.ce});
            chk("tl_done_valid", {31'd0, done_valid}, {31'd0, e.dv});
            if (e.ce) chk("tl_inc", {31'd0, dly_inc}, {31'd0, e.inc});
            if (e.ld) chk("tl_cntvaluein", {27'd0, dly_cntvaluein}, e.tap);
            if (e.dv) begin
              chk("tl_done_tap", {27'd0, done_tap}, e.tap);
              chk("tl_done_err", {31'd0, done_err}, {31'd0, e.err});
            end
          end else begin
            chk("idle_ld", {31'd0, dly_ld}, 0);
            chk("idle_ce", {31'd0, dly_ce}, 0);
            chk("idle_done_valid", {31'd0, done_valid}, 0);
          end
        end
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("ready_timeout", 0, 1);
  endtask

  // Issue one request, observe it to done_valid, and check its totals.
  task automatic run_op(input string nm, input int tgt, input bit walk, input int exp_lat,
                        input int exp_ld, input int exp_ce, input int exp_inc,
                        input int exp_dtap, input bit exp_err);
    bit ok;
    int cur, lat, nld, nce, ninc, gapbad, last_ce;
    logic [TAP_W-1:0] dtap;
    logic derr;
    wait_ready(ok);
    if (!ok) return;
    req_valid = 1'b1; req_tap = TAP_W'(tgt); req_walk = walk;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cur = int'(tap_m);
    if (tl_en) build_timeline(tgt, walk, cur);
    lat = -1; nld = 0; nce = 0; ninc = 0; gapbad = 0; last_ce = 0; dtap = '0; derr = 1'b0;
    for (int i = 1; i < 2000; i++) begin
      @(negedge clk);
      if (dly_ld) begin
        nld++;
        chk({nm, "_cntvaluein"}, {27'd0, dly_cntvaluein}, tgt);
      end
      if (dly_ce) begin
        nce++;
        if (dly_inc) ninc++;
        if (last_ce > 0 && (i - last_ce) != int'(SETTLE) + 1) gapbad++;
        last_ce = i;
      end
      if (done_valid) begin lat = i; dtap = done_tap; derr = done_err; break; end
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_ld_pulses"}, nld, exp_ld);
    chk({nm, "_ce_pulses"}, nce, exp_ce);
    chk({nm, "_inc_pulses"}, ninc, exp_inc);
    if (exp_ce > 1) chk({nm, "_ce_spacing"}, gapbad, 0);
    chk({nm, "_done_tap"}, {27'd0, dtap}, exp_dtap);
    chk({nm, "_done_err"}, {31'd0, derr}, {31'd0, exp_err});
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_req_ready"}, {31'd0, req_ready}, 0);
    chk({nm, "_done_valid"}, {31'd0, done_valid}, 0);
    chk({nm, "_done_err"}, {31'd0, done_err}, 0);
    chk({nm, "_done_tap"}, {27'd0, done_tap}, 0);
    chk({nm, "_ld"}, {31'd0, dly_ld}, 0);
    chk({nm, "_ce"}, {31'd0, dly_ce}, 0);
    chk({nm, "_inc"}, {31'd0, dly_inc}, 0);
    chk({nm, "_cntvaluein"}, {27'd0, dly_cntvaluein}, 0);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    bit ok;
    int cur, n, dv_seen;
    reset = 1'b1; rdy_in = 1'b0; req_valid = 1'b0; req_tap = '0; req_walk = 1'b0;

    fork
      compare_loop();
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Ready gating: 10 cycles with rdy_in low, then raise it.
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("wait_rdy_req_ready", {31'd0, req_ready}, 0);
      if (i >= 1) chk("wait_rdy_busy", {31'd0, busy}, 1);
    end
    @(posedge clk); #1 rdy_in = 1'b1;
    @(negedge clk);
    chk("rdy_rise_same_cycle", {31'd0, req_ready}, 0);
    @(negedge clk);
    chk("rdy_rise_next_cycle", {31'd0, req_ready}, 1);
    tl_en = 1'b1;

    // Absolute load, walks up/down, no-op walk.
    run_op("abs17", 17, 1'b0, 7, 1, 0, 0, 17, 1'b0);
    run_op("abs3", 3, 1'b0, 7, 1, 0, 0, 3, 1'b0);
    run_op("walk3to7", 7, 1'b1, 22, 0, 4, 4, 7, 1'b0);
    run_op("abs31", 31, 1'b0, 7, 1, 0, 0, 31, 1'b0);
    run_op("walk31to0", 0, 1'b1, 157, 0, 31, 0, 0, 1'b0);
    run_op("abs12", 12, 1'b0, 7, 1, 0, 0, 12, 1'b0);
    run_op("walk12to12", 12, 1'b1, 2, 0, 0, 0, 12, 1'b0);
    run_op("abs0", 0, 1'b0, 7, 1, 0, 0, 0, 1'b0);

    // rdy_in lost during SETTLE of a walk 0 -> 9.
    tl_en = 1'b0;
    wait_ready(ok);
    req_valid = 1'b1; req_tap = TAP_W'(9); req_walk = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rdy_in = 1'b0;
    dv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_valid) begin
        dv_seen = 1;
        chk("abort_done_err", {31'd0, done_err}, 1);
        chk("abort_done_tap", {27'd0, done_tap}, {27'd0, tap_m});
        chk("abort_done_tap_lit", {27'd0, done_tap}, 1);
        break;
      end
    end
    chk("abort_done_seen", dv_seen, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_wait_rdy_ready", {31'd0, req_ready}, 0);
      chk("abort_wait_rdy_busy", {31'd0, busy}, 1);
      chk("abort_no_second_done", {31'd0, done_valid}, 0);
    end
    @(posedge clk); #1 rdy_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_recover_ready", {31'd0, req_ready}, 1);

    // Reset asserted mid-walk abandons the operation silently.
    wait_ready(ok);
    req_valid = 1'b1; req_tap = TAP_W'(20); req_walk = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1 reset = 1'b0;
    dv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_valid) dv_seen++;
    end
    chk("midreset_no_done", dv_seen, 0);
    chk("midreset_done_tap", {27'd0, done_tap}, 0);
    chk("midreset_done_err", {31'd0, done_err}, 0);
    chk("midreset_cntvaluein", {27'd0, dly_cntvaluein}, 0);

    // Controller resumes from wherever the tap was left.
    tl_en = 1'b1;
    cur = int'(tap_m);
    n = (cur > 4) ? cur - 4 : 4 - cur;
    run_op("walk_to4", 4, 1'b1, (n > 0) ? n * (int'(SETTLE) + 1) + 2 : 2, 0, n,
           (cur < 4) ? n : 0, 4, 1'b0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/idelay_tap_ctrl.md
IDELAY_TAP_CTRL -- requirements
Module: idelay_tap_ctrl

Interface
REQ-001 The module SHALL have parameter TAP_W, default 5, meaning tap-count width of the controlled IDELAYE2.
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 4, meaning clk cycles waited after every LD or CE pulse before the next action; legal range 1..255.
REQ-003 The module SHALL have port clk, input, 1, the single clock, which is also the IDELAYE2 C input.
REQ-004 The module SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 The module SHALL have port rdy_in, input, 1, the IDELAYCTRL RDY output.
REQ-006 The module SHALL have ports req_valid (input, 1), req_ready (output, 1), req_tap (input, TAP_W) and req_walk (input, 1); req_walk=0 selects absolute load and req_walk=1 selects a one-tap-at-a-time walk.
REQ-007 The module SHALL have ports done_valid (output, 1, one-cycle pulse), done_tap (output, TAP_W, final readback) and done_err (output, 1).
REQ-008 The module SHALL have ports dly_ld, dly_ce and dly_inc (outputs, 1 each), dly_cntvaluein (output, TAP_W) and dly_cntvalueout (input, TAP_W), all connected to the IDELAYE2.
REQ-009 The module SHALL have port busy, output, 1, which is high in every state except IDLE.

Function
REQ-010 States SHALL be WAIT_RDY, IDLE, LOAD, STEP, SETTLE, CHECK and DONE.
REQ-011 WAIT_RDY SHALL move to IDLE on the first cycle that rdy_in=1; req_ready=0 while in WAIT_RDY.
REQ-012 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid and req_ready are both 1, and req_tap and req_walk are captured on that cycle.
REQ-013 An accepted absolute request SHALL go to LOAD, which drives dly_ld=1 and dly_cntvaluein=target for exactly one cycle and then goes to SETTLE.
REQ-014 An accepted walk request SHALL go to CHECK if target equals dly_cntvalueout, and otherwise to STEP.
REQ-015 STEP SHALL drive dly_ce=1 for exactly one cycle, with dly_inc=1 if target exceeds the current tap and dly_inc=0 otherwise, and SHALL then go to SETTLE.
REQ-016 SETTLE SHALL hold for exactly SETTLE_CYCLES cycles, using a down-counter loaded on entry.
REQ-017 On exit from SETTLE, a walk SHALL return to STEP while dly_cntvalueout differs from target, and SHALL otherwise go to CHECK; an absolute load SHALL always go to CHECK.
REQ-018 CHECK SHALL take one cycle, latch done_tap=dly_cntvalueout and set done_err=(dly_cntvalueout != target), then go to DONE.
REQ-019 DONE SHALL pulse done_valid=1 for one cycle and then go to IDLE; a new request is not accepted in the same cycle as DONE.
REQ-020 A walk SHALL take a step count equal to |target-current| and SHALL never wrap, so 31 to 0 takes 31 decrements and no wrap through 0.
REQ-021 A walk SHALL be aborted after 2^TAP_W steps, with done_err=1.
REQ-022 dly_ld and dly_ce SHALL never be high in the same cycle, and each SHALL be high for at most one cycle at a time.
REQ-023 If rdy_in=0 in any state other than WAIT_RDY and IDLE, the operation SHALL abort through DONE with done_err=1 and done_tap=dly_cntvalueout, and then go to WAIT_RDY instead of IDLE.
REQ-024 If rdy_in=0 in IDLE, the module SHALL go to WAIT_RDY.

Reset
REQ-025 While reset=1 at a clk edge, the state SHALL become WAIT_RDY, and req_ready, done_valid, done_err, dly_ld, dly_ce, dly_inc and busy SHALL be 0; busy goes to 1 in the cycle after reset releases.
REQ-026 While reset=1 at a clk edge, done_tap, dly_cntvaluein, the captured target and the settle and step counters SHALL be 0.
REQ-027 A reset asserted mid-operation SHALL abandon the operation without issuing a done_valid pulse.

Structure
REQ-028 Package idelay_ctrl_pkg SHALL hold the state enumeration, the TAP_W default and the SETTLE_CYCLES default.
REQ-029 The SETTLE countdown SHALL be the sub-module idelay_settle_timer, with ports clk, reset, start, done and parameter SETTLE_CYCLES.
REQ-030 The bench SHALL model IDELAYE2 tap behaviour: LD loads cntvaluein, CE with INC steps by 1, and the readback is registered.

Verification
REQ-031 Sequence: hold rdy_in=0 for 10 cycles, then raise it -> req_ready stays 0 for those 10 cycles and rises 1 cycle after rdy_in rises.
REQ-032 Absolute load of tap 17 -> exactly 1 dly_ld pulse with cntvaluein=17; done_valid occurs 1+4+1+1 cycles after acceptance, with done_tap=17 and done_err=0.
REQ-033 Walk from 3 to 7 -> 4 dly_ce pulses with dly_inc=1, spaced 5 cycles apart; done_tap=7 and done_err=0.
REQ-034 Walk from 31 to 0 -> 31 dly_ce pulses with dly_inc=0 and no wrap; done_tap=0.
REQ-035 Walk with target equal to the current tap of 12 -> no dly_ce pulse; done_valid occurs 2 cycles after acceptance, with done_tap=12.
REQ-036 Drop rdy_in during SETTLE of a walk from 0 to 9 -> done_valid with done_err=1, then WAIT_RDY; a reset asserted mid-walk instead -> no done_valid and all outputs 0.
